control_sequencer: RTL and testbench

// Moore-style control unit driving the datapath (bus) control strobes for instruction fetch plus the

---
 rtl/control_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// ============================================================================
// Module      : control_sequencer
// Description : Moore FSM issuing one-cycle datapath strobes for fetch and
//               single-step register-transfer instructions, plus status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer #(
   parameter int       CNT_W   = 16,
   parameter bit [4:0] OP_IN   = 5'b10110,
   parameter bit [4:0] OP_OUT  = 5'b10111,
   parameter bit [4:0] OP_MFHI = 5'b11000,
   parameter bit [4:0] OP_MFLO = 5'b11001,
   parameter bit [4:0] OP_JR   = 5'b10100,
   parameter bit [4:0] OP_NOP  = 5'b11010,
   parameter bit [4:0] OP_HALT = 5'b11011
) (
   input  logic             clock,
   input  logic             clear,
   input  logic [31:0]      ir,
   input  logic             stop,
   output logic             PCout,
   output logic             MARin,
   output logic             IncPC,
   output logic             Zlowin,
   output logic             ZLOout,
   output logic             PCin,
   output logic             read,
   output logic             MDRin,
   output logic             MDRout,
   output logic             IRin,
   output logic             Gra,
   output logic             Rin,
   output logic             Rout,
   output logic             Inportout,
   output logic             OutPortin,
   output logic             HIout,
   output logic             LOout,
   output logic             Grb,
   output logic             Grc,
   output logic             BAout,
   output logic             CON_in,
   output logic             Yin,
   output logic             Zhighin,
   output logic             write,
   output logic             HIin,
   output logic             LOin,
   output logic             run,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_RST  = 3'd0,
      S_T0   = 3'd1,
      S_T1   = 3'd2,
      S_T2   = 3'd3,
      S_T3   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             r_illegal;
   logic [CNT_W-1:0] r_retired;
   logic [4:0]       w_opcode;
   logic             w_legal;
   logic             w_unused_ir;

   assign w_opcode    = ir[31:27];
   assign w_unused_ir = ^ir[26:0];

   assign w_legal = (w_opcode == OP_IN)   || (w_opcode == OP_OUT)  ||
                    (w_opcode == OP_MFHI) || (w_opcode == OP_MFLO) ||
                    (w_opcode == OP_JR)   || (w_opcode == OP_NOP)  ||
                    (w_opcode == OP_HALT);

   // Leaving T3 retires the instruction whatever its opcode, halt and illegal included.
   always_ff @(posedge clock) begin
      if (clear) begin
         r_state   <= S_RST;
         r_illegal <= 1'b0;
         r_retired <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_T3) begin
            r_retired <= r_retired + CNT_W'(1);
            if (!w_legal) begin
               r_illegal <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_next    = r_state;
      run       = 1'b0;
      PCout     = 1'b0;
      MARin     = 1'b0;
      IncPC     = 1'b0;
      Zlowin    = 1'b0;
      ZLOout    = 1'b0;
      PCin      = 1'b0;
      read      = 1'b0;
      MDRin     = 1'b0;
      MDRout    = 1'b0;
      IRin      = 1'b0;
      Gra       = 1'b0;
      Rin       = 1'b0;
      Rout      = 1'b0;
      Inportout = 1'b0;
      OutPortin = 1'b0;
      HIout     = 1'b0;
      LOout     = 1'b0;
      case (r_state)
         S_RST: begin
            w_next = S_T0;
         end
         S_T0: begin
            run    = 1'b1;
            PCout  = 1'b1;
            MARin  = 1'b1;
            IncPC  = 1'b1;
            Zlowin = 1'b1;
            w_next = S_T1;
         end
         S_T1: begin
            run    = 1'b1;
            ZLOout = 1'b1;
            PCin   = 1'b1;
            read   = 1'b1;
            MDRin  = 1'b1;
            w_next = S_T2;
         end
         S_T2: begin
            run    = 1'b1;
            MDRout = 1'b1;
            IRin   = 1'b1;
            w_next = S_T3;
         end
         S_T3: begin
            run = 1'b1;
            // stop is only honoured here, so an in-flight instruction always completes.
            w_next = ((w_opcode == OP_HALT) || stop) ? S_HALT : S_T0;
            if (w_opcode == OP_OUT) begin
               Gra       = 1'b1;
               Rout      = 1'b1;
               OutPortin = 1'b1;
            end else if (w_opcode == OP_IN) begin
               Gra       = 1'b1;
               Rin       = 1'b1;
               Inportout = 1'b1;
            end else if (w_opcode == OP_MFHI) begin
               Gra   = 1'b1;
               Rin   = 1'b1;
               HIout = 1'b1;
            end else if (w_opcode == OP_MFLO) begin
               Gra   = 1'b1;
               Rin   = 1'b1;
               LOout = 1'b1;
            end else if (w_opcode == OP_JR) begin
               Gra  = 1'b1;
               Rout = 1'b1;
               PCin = 1'b1;
            end
         end
         S_HALT: begin
            w_next = S_HALT;
         end
         default: begin
            w_next = S_RST;
         end
      endcase
   end

   assign Grb     = 1'b0;
   assign Grc     = 1'b0;
   assign BAout   = 1'b0;
   assign CON_in  = 1'b0;
   assign Yin     = 1'b0;
   assign Zhighin = 1'b0;
   assign write   = 1'b0;
   assign HIin    = 1'b0;
   assign LOin    = 1'b0;

   assign illegal = r_illegal;
   assign retired = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// Module      : tb_control_sequencer
// Description : Directed plus randomized bench for control_sequencer against a
//               step-counting reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

   localparam bit [4:0] C_OP_IN   = 5'b10110;
   localparam bit [4:0] C_OP_OUT  = 5'b10111;
   localparam bit [4:0] C_OP_MFHI = 5'b11000;
   localparam bit [4:0] C_OP_MFLO = 5'b11001;
   localparam bit [4:0] C_OP_JR   = 5'b10100;
   localparam bit [4:0] C_OP_NOP  = 5'b11010;
   localparam bit [4:0] C_OP_HALT = 5'b11011;

   // Bit positions in the packed strobe vector (see pack order below).
   localparam int B_PCOUT = 25, B_MARIN = 24, B_INCPC = 23, B_ZLOWIN = 22;
   localparam int B_ZLOOUT = 21, B_PCIN = 20, B_READ = 19, B_MDRIN = 18;
   localparam int B_MDROUT = 17, B_IRIN = 16, B_GRA = 15, B_RIN = 14, B_ROUT = 13;
   localparam int B_INPORTOUT = 12, B_OUTPORTIN = 11, B_HIOUT = 10, B_LOOUT = 9;

   localparam int M_RST = 0, M_RUN = 1, M_HALT = 2;

   logic        clock = 1'b0;
   logic        clear = 1'b1;
   logic        stop  = 1'b0;
   logic [31:0] ir    = 32'h0;

   logic PCout, MARin, IncPC, Zlowin, ZLOout, PCin, read, MDRin, MDRout, IRin;
   logic Gra, Rin, Rout, Inportout, OutPortin, HIout, LOout;
   logic Grb, Grc, BAout, CON_in, Yin, Zhighin, write, HIin, LOin;
   logic        run, illegal;
   logic [15:0] retired;

   int          checks   = 0;
   int          failures = 0;
   int          m_mode   = M_RST;
   int          m_step   = 0;
   int unsigned m_ret    = 0;
   bit          m_ill    = 1'b0;

   always #5 clock = ~clock;

   control_sequencer dut (
      .clock(clock), .clear(clear), .ir(ir), .stop(stop),
      .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zlowin(Zlowin),
      .ZLOout(ZLOout), .PCin(PCin), .read(read), .MDRin(MDRin),
      .MDRout(MDRout), .IRin(IRin), .Gra(Gra), .Rin(Rin), .Rout(Rout),
      .Inportout(Inportout), .OutPortin(OutPortin), .HIout(HIout), .LOout(LOout),
      .Grb(Grb), .Grc(Grc), .BAout(BAout), .CON_in(CON_in), .Yin(Yin),
      .Zhighin(Zhighin), .write(write), .HIin(HIin), .LOin(LOin),
      .run(run), .illegal(illegal), .retired(retired)
   );

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [25:0] dut_strobes();
      return {PCout, MARin, IncPC, Zlowin, ZLOout, PCin, read, MDRin, MDRout, IRin,
              Gra, Rin, Rout, Inportout, OutPortin, HIout, LOout,
              Grb, Grc, BAout, CON_in, Yin, Zhighin, write, HIin, LOin};
   endfunction

   function automatic bit op_legal(input logic [4:0] op);
      return op inside {C_OP_IN, C_OP_OUT, C_OP_MFHI, C_OP_MFLO, C_OP_JR, C_OP_NOP, C_OP_HALT};
   endfunction

   // Strobe table: which named strobes each step of the instruction raises.
   function automatic logic [25:0] exp_strobes();
      logic [25:0] e;
      logic [4:0]  op;
      e  = '0;
      op = ir[31:27];
      if (m_mode == M_RUN) begin
         case (m_step)
            0: begin e[B_PCOUT] = 1; e[B_MARIN] = 1; e[B_INCPC] = 1; e[B_ZLOWIN] = 1; end
            1: begin e[B_ZLOOUT] = 1; e[B_PCIN] = 1; e[B_READ] = 1; e[B_MDRIN] = 1; end
            2: begin e[B_MDROUT] = 1; e[B_IRIN] = 1; end
            default: begin
               if (op == C_OP_OUT)  begin e[B_GRA] = 1; e[B_ROUT] = 1; e[B_OUTPORTIN] = 1; end
               if (op == C_OP_IN)   begin e[B_GRA] = 1; e[B_RIN]  = 1; e[B_INPORTOUT] = 1; end
               if (op == C_OP_MFHI) begin e[B_GRA] = 1; e[B_RIN]  = 1; e[B_HIOUT] = 1; end
               if (op == C_OP_MFLO) begin e[B_GRA] = 1; e[B_RIN]  = 1; e[B_LOOUT] = 1; end
               if (op == C_OP_JR)   begin e[B_GRA] = 1; e[B_ROUT] = 1; e[B_PCIN] = 1; end
            end
         endcase
      end
      return e;
   endfunction

   task automatic model_edge();
      if (clear) begin
         m_mode = M_RST; m_step = 0; m_ret = 0; m_ill = 1'b0;
      end else if (m_mode == M_RST) begin
         m_mode = M_RUN; m_step = 0;
      end else if (m_mode == M_RUN) begin
         if (m_step < 3) begin
            m_step++;
         end else begin
            m_ret = (m_ret + 1) % 65536;
            if (!op_legal(ir[31:27])) m_ill = 1'b1;
            if (ir[31:27] == C_OP_HALT || stop) m_mode = M_HALT;
            else m_step = 0;
         end
      end
   endtask

   task automatic check_all();
      check_value("strobes", {6'b0, dut_strobes()}, {6'b0, exp_strobes()});
      check_value("run", {31'b0, run}, {31'b0, (m_mode == M_RUN)});
      check_value("illegal", {31'b0, illegal}, {31'b0, m_ill});
      check_value("retired", {16'b0, retired}, m_ret);
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
      check_all();
   endtask

   logic [4:0] ops [7] = '{C_OP_IN, C_OP_OUT, C_OP_MFHI, C_OP_MFLO, C_OP_JR, C_OP_NOP, C_OP_HALT};

   initial begin
      logic [4:0] seq [4] = '{C_OP_IN, C_OP_MFHI, C_OP_MFLO, C_OP_JR};
      logic [31:0] r;
      int k;

      // Two reset cycles, then release into T0.
      tick(); tick();
      check_value("rst_retired", {16'b0, retired}, 32'd0);
      clear = 1'b0; ir = 32'hB880_0000;
      tick();
      check_value("t0_run", {31'b0, run}, 32'd1);
      check_value("t0_pcout", {31'b0, PCout}, 32'd1);
      repeat (3) tick();
      check_value("t3_outportin", {31'b0, OutPortin}, 32'd1);
      tick();
      check_value("out_retired", {16'b0, retired}, 32'd1);

      // Back-to-back in, mfhi, mflo, jr.
      foreach (seq[i]) begin
         ir = {seq[i], 27'h0};
         repeat (4) tick();
      end
      check_value("seq_retired", {16'b0, retired}, 32'd5);

      // Halt freezes everything until clear.
      ir = 32'hD800_0000;
      repeat (4) tick();
      repeat (10) tick();
      check_value("halt_run", {31'b0, run}, 32'd0);
      check_value("halt_retired", {16'b0, retired}, 32'd6);
      clear = 1'b1; tick(); clear = 1'b0; tick();

      // stop outside T3 is ignored; stop in T3 halts after the out pulse.
      ir = {C_OP_OUT, 27'h0};
      tick(); stop = 1'b1; tick(); stop = 1'b0; tick(); tick();
      check_value("stop_ignored", {31'b0, run}, 32'd1);
      repeat (3) tick();
      stop = 1'b1; tick(); stop = 1'b0;
      check_value("stop_halt", {31'b0, run}, 32'd0);
      clear = 1'b1; tick(); clear = 1'b0; tick();

      // Abort mid-fetch, then an illegal opcode sets the sticky flag.
      tick(); clear = 1'b1; tick();
      check_value("abort_pcin", {31'b0, PCin}, 32'd0);
      clear = 1'b0; ir = 32'hF800_0000;
      repeat (5) tick();
      check_value("illegal_set", {31'b0, illegal}, 32'd1);
      ir = {C_OP_NOP, 27'h0};
      repeat (8) tick();
      check_value("illegal_sticky", {31'b0, illegal}, 32'd1);
      clear = 1'b1; tick(); clear = 1'b0;
      check_value("illegal_clr", {31'b0, illegal}, 32'd0);

      // Randomized run against the model.
      for (int n = 0; n < 4000; n++) begin
         tick();
         clear = ($urandom_range(0, 199) == 0) || (m_mode == M_HALT && $urandom_range(0, 7) == 0);
         stop  = ($urandom_range(0, 9) == 0);
         if (m_mode == M_RUN && m_step == 0) begin
            r = $urandom();
            k = $urandom_range(0, 11);
            if (k < 7)       ir = {ops[k], r[26:0]};
            else if (k < 10) ir = {ops[$urandom_range(0, 5)], r[26:0]};
            else             ir = r;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
